// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between
// the I-cache (client 0) and D-cache (client 1), with per-client FIFOs.
module mem_arbiter #(
  parameter int PA_WIDTH   = 32,
  parameter int LINE_WIDTH = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              i_req_enable,
  input  logic [1:0]              i_req_type,
  input  logic [2*PA_WIDTH-1:0]   i_req_addr,
  input  logic [2*LINE_WIDTH-1:0] i_req_data,
  output logic [1:0]              o_req_full,
  output logic [1:0]              o_resp_enable,
  output logic [PA_WIDTH-1:0]     o_resp_addr,
  output logic [LINE_WIDTH-1:0]   o_resp_data,
  input  logic [1:0]              i_resp_ack,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [PA_WIDTH-1:0]     o_mem_addr,
  output logic [LINE_WIDTH-1:0]   o_mem_wdata,
  input  logic                    i_mem_ready,
  input  logic                    i_mem_rvalid,
  input  logic [LINE_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  state_t r_state;
  logic   r_rr;
  logic   r_owner;

  logic [1:0]            w_full;
  logic [1:0]            w_nemp;
  logic [1:0]            w_push;
  logic [1:0]            w_pop;
  logic                  w_win;
  logic                  w_h_we   [2];
  logic [PA_WIDTH-1:0]   w_h_addr [2];
  logic [LINE_WIDTH-1:0] w_h_data [2];

  assign w_win      = w_nemp[r_rr] ? r_rr : ~r_rr;
  assign o_req_full = w_full;

  for (genvar c = 0; c < 2; c++) begin : g_fifo
    logic                  r_we   [FIFO_DEPTH];
    logic [PA_WIDTH-1:0]   r_addr [FIFO_DEPTH];
    logic [LINE_WIDTH-1:0] r_data [FIFO_DEPTH];
    logic [AW-1:0]         r_wp;
    logic [AW-1:0]         r_rp;
    logic [AW:0]           r_cnt;

    assign w_full[c] = (r_cnt == LP_FULL);
    assign w_nemp[c] = |r_cnt;
    assign w_push[c] = i_req_enable[c] && !w_full[c];
    assign w_pop[c]  = (r_state == S_IDLE) && w_nemp[c]
                    && (w_win == 1'(c));

    assign w_h_we[c]   = r_we[r_rp];
    assign w_h_addr[c] = r_addr[r_rp];
    assign w_h_data[c] = r_data[r_rp];

    always_ff @(posedge clk) begin
      if (w_push[c]) begin
        r_we[r_wp]   <= i_req_type[c];
        r_addr[r_wp] <= i_req_addr[c*PA_WIDTH +: PA_WIDTH];
        r_data[r_wp] <= i_req_data[c*LINE_WIDTH +: LINE_WIDTH];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push[c]) r_wp <= r_wp + AW'(1);
        if (w_pop[c])  r_rp <= r_rp + AW'(1);
        r_cnt <= r_cnt + (AW+1)'(w_push[c])
                       - (AW+1)'(w_pop[c]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rr          <= 1'b0;
      r_owner       <= 1'b0;
      o_mem_req     <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_resp_enable <= 2'b00;
      o_resp_addr   <= '0;
      o_resp_data   <= '0;
      o_overflow    <= 1'b0;
    end else begin
      if (|(i_req_enable & w_full)) o_overflow <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (|w_nemp) begin
            r_owner     <= w_win;
            o_mem_we    <= w_h_we[w_win];
            o_mem_addr  <= w_h_addr[w_win];
            o_mem_wdata <= w_h_data[w_win];
            r_state     <= S_ISSUE;
          end
        end
        // First ISSUE cycle loads the request; it then holds until ready.
        S_ISSUE: begin
          if (!o_mem_req) begin
            o_mem_req <= 1'b1;
          end else if (i_mem_ready) begin
            o_mem_req <= 1'b0;
            if (o_mem_we) begin
              r_rr    <= ~r_owner;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (i_mem_rvalid) begin
            o_resp_data   <= i_mem_rdata;
            o_resp_addr   <= o_mem_addr;
            o_resp_enable <= r_owner ? 2'b10 : 2'b01;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_resp_ack[r_owner]) begin
            o_resp_enable <= 2'b00;
            r_rr          <= ~r_owner;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for the main flows,
// hand sequences for stalls, FIFO overflow and mid-flight reset.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   en, typ, ack;
  logic [31:0]  a0, a1;
  logic [127:0] wd, rd;
  logic         rdy, rv;

  logic [1:0]   req_full, resp_en;
  logic [31:0]  resp_addr, mem_addr;
  logic [127:0] resp_data, mem_wdata;
  logic         mem_req, mem_we, ovf;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] Z  = '0;
  localparam logic [127:0] D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D2 = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
  localparam logic [127:0] D3 = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
  localparam logic [127:0] D4 = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
  localparam logic [127:0] D5 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
  localparam logic [127:0] W  = 128'hFEED_FACE_0000_1111_2222_3333_4444_5555;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_enable  (en),
    .i_req_type    (typ),
    .i_req_addr    ({a1, a0}),
    .i_req_data    ({wd, wd}),
    .o_req_full    (req_full),
    .o_resp_enable (resp_en),
    .o_resp_addr   (resp_addr),
    .o_resp_data   (resp_data),
    .i_resp_ack    (ack),
    .o_mem_req     (mem_req),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .i_mem_ready   (rdy),
    .i_mem_rvalid  (rv),
    .i_mem_rdata   (rd),
    .o_overflow    (ovf)
  );

  typedef struct {
    logic         rst;
    logic [1:0]   en, typ, ack;
    logic [31:0]  a0, a1;
    logic [127:0] wd, rd;
    logic         rdy, rv;
    logic         e_req, e_we;
    logic [31:0]  e_addr;
    logic [127:0] e_wd;
    logic [1:0]   e_ren;
    logic [31:0]  e_raddr;
    logic [127:0] e_rd;
    logic [1:0]   e_full;
    logic         e_ovf;
  } vec_t;

  vec_t tbl[$];
  vec_t t;

  function automatic vec_t v(
    input int r, input int e, input int ty, input int x0, input int x1,
    input logic [127:0] w, input int k, input int rr, input int rvv,
    input logic [127:0] rdd,
    input int q, input int we, input int ad, input logic [127:0] ewd,
    input int ren, input int rad, input logic [127:0] erd,
    input int fl, input int ov);
    vec_t o;
    o.rst = (r != 0);      o.en = 2'(e);        o.typ = 2'(ty);
    o.a0 = x0;             o.a1 = x1;           o.wd = w;
    o.ack = 2'(k);         o.rdy = (rr != 0);   o.rv = (rvv != 0);
    o.rd = rdd;            o.e_req = (q != 0);  o.e_we = (we != 0);
    o.e_addr = ad;         o.e_wd = ewd;        o.e_ren = 2'(ren);
    o.e_raddr = rad;       o.e_rd = erd;        o.e_full = 2'(fl);
    o.e_ovf = (ov != 0);
    return o;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    en = 2'b00; typ = 2'b00; ack = 2'b00;
    a0 = '0; a1 = '0; wd = '0; rd = '0;
    rdy = 1'b0; rv = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();

    // T1: single client-0 read, rvalid two cycles after acceptance
    tbl.push_back(v(1,0,0,0,0,Z,0,0,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,1,0,'h100,0,Z,0,1,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,1,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,1,0,Z, 1,0,'h100,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,1,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,0,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,0,1,D1, 0,0,0,Z,1,'h100,D1,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,0,0,Z, 0,0,0,Z,1,'h100,D1,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,2,0,0,Z, 0,0,0,Z,1,'h100,D1,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,1,0,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,0,0,Z, 0,0,0,Z,0,0,Z,0,0));
    // T2: simultaneous reads with rr=0
    tbl.push_back(v(1,0,0,0,0,Z,0,0,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,3,0,'h300,'h400,Z,0,0,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,0,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,1,0,Z, 1,0,'h300,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,1,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,0,1,D1, 0,0,0,Z,1,'h300,D1,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,1,0,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,0,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,0,0,Z, 1,0,'h400,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,1,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,0,1,D2, 0,0,0,Z,2,'h400,D2,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,1,0,0,Z, 0,0,0,Z,2,'h400,D2,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,2,0,0,Z, 0,0,0,Z,0,0,Z,0,0));
    // T3: client-1 eviction then refill of the same line
    tbl.push_back(v(0,2,2,0,'h200,W,0,0,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,2,0,0,'h200,Z,0,0,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,0,0,Z, 1,1,'h200,W,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,1,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,0,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,0,0,Z, 1,0,'h200,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,1,0,Z, 0,0,0,Z,0,0,Z,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,0,0,1,D3, 0,0,0,Z,2,'h200,D3,0,0));
    tbl.push_back(v(0,0,0,0,0,Z,2,0,0,Z, 0,0,0,Z,0,0,Z,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      rst = t.rst; en = t.en; typ = t.typ; a0 = t.a0; a1 = t.a1;
      wd = t.wd; ack = t.ack; rdy = t.rdy; rv = t.rv; rd = t.rd;
      step();
      chk($sformatf("v%0d.req", i), 128'(mem_req), 128'(t.e_req));
      if (t.e_req) begin
        chk($sformatf("v%0d.we", i), 128'(mem_we), 128'(t.e_we));
        chk($sformatf("v%0d.addr", i), 128'(mem_addr), 128'(t.e_addr));
        if (t.e_we)
          chk($sformatf("v%0d.wdata", i), mem_wdata, t.e_wd);
      end
      chk($sformatf("v%0d.resp_en", i), 128'(resp_en), 128'(t.e_ren));
      if (t.e_ren != 2'b00) begin
        chk($sformatf("v%0d.raddr", i), 128'(resp_addr), 128'(t.e_raddr));
        chk($sformatf("v%0d.rdata", i), resp_data, t.e_rd);
      end
      chk($sformatf("v%0d.full", i), 128'(req_full), 128'(t.e_full));
      chk($sformatf("v%0d.ovf", i), 128'(ovf), 128'(t.e_ovf));
    end

    // T4: write stalled five cycles in ISSUE
    do_reset();
    en = 2'b01; typ = 2'b01; a0 = 32'h500; wd = D4;
    step();
    idle_in();
    step();
    step();
    chk("t4.req", 128'(mem_req), 128'(1));
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t4.hold%0d.req", k), 128'(mem_req), 128'(1));
      chk($sformatf("t4.hold%0d.addr", k), 128'(mem_addr), 128'(32'h500));
      chk($sformatf("t4.hold%0d.wd", k), mem_wdata, D4);
    end
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("t4.accept", 128'(mem_req), 128'(0));
    step();
    chk("t4.idle.req", 128'(mem_req), 128'(0));
    chk("t4.idle.resp", 128'(resp_en), 128'(0));

    // T5: fill client-0 FIFO while memory stalls on a client-1 read
    do_reset();
    en = 2'b10; a1 = 32'h600;
    step();
    idle_in();
    step();
    step();
    chk("t5.busy", 128'(mem_addr), 128'(32'h600));
    for (int k = 0; k < 5; k++) begin
      en = 2'b01; a0 = 32'h700 + 32'(k * 16);
      step();
      chk($sformatf("t5.push%0d.full", k), 128'(req_full),
          128'((k >= 3) ? 2'b01 : 2'b00));
      chk($sformatf("t5.push%0d.ovf", k), 128'(ovf), 128'(k == 4));
    end
    idle_in();
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t5.sticky%0d", k), 128'(ovf), 128'(1));
    end
    chk("t5.full", 128'(req_full), 128'(2'b01));

    // T6: reset while waiting for read data
    do_reset();
    en = 2'b01; a0 = 32'h800;
    step();
    en = 2'b10; a1 = 32'h900; a0 = '0;
    step();
    idle_in();
    rdy = 1'b1;
    step();
    step();
    rdy = 1'b0;
    chk("t6.wait.req", 128'(mem_req), 128'(0));
    rst = 1'b1;
    #1;
    chk("t6.rst.req", 128'(mem_req), 128'(0));
    chk("t6.rst.we", 128'(mem_we), 128'(0));
    chk("t6.rst.addr", 128'(mem_addr), 128'(0));
    chk("t6.rst.wd", mem_wdata, Z);
    chk("t6.rst.resp", 128'(resp_en), 128'(0));
    chk("t6.rst.raddr", 128'(resp_addr), 128'(0));
    chk("t6.rst.rdata", resp_data, Z);
    chk("t6.rst.full", 128'(req_full), 128'(0));
    chk("t6.rst.ovf", 128'(ovf), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    rv = 1'b1; rd = D5;
    step();
    rv = 1'b0;
    chk("t6.rv.resp", 128'(resp_en), 128'(0));
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6.empty%0d", k), 128'(mem_req), 128'(0));
      chk($sformatf("t6.noresp%0d", k), 128'(resp_en), 128'(0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
